// File: rtl/mem_pkg.sv
// Shared encodings and defaults for the memory-stage sequencer.
package mem_pkg;

  localparam int          ADDR_W_DEFAULT   = 12;
  localparam logic [15:0] SP_RESET_DEFAULT = 16'h0FFF;

  typedef enum logic [2:0] {
    MEM_NONE   = 3'd0,
    MEM_LOAD   = 3'd1,
    MEM_STORE  = 3'd2,
    MEM_PUSH   = 3'd3,
    MEM_POP    = 3'd4,
    MEM_PUSH32 = 3'd5,
    MEM_POP32  = 3'd6
  } mem_op_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  // True when addr lies at or above 2**addr_w.
  function automatic logic out_of_range(input logic [15:0] addr, input int addr_w);
    return (addr_w < 16) && ((addr >> addr_w) != 16'h0);
  endfunction

endpackage

// File: rtl/stack_pointer_unit.sv
// Stack pointer register: applies a signed step of -2..+2 when commit is high.
module stack_pointer_unit
  import mem_pkg::*;
#(
  parameter logic [15:0] SP_RESET = SP_RESET_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic signed [2:0] step,
  input  logic              commit,
  output logic [15:0]       sp
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sp <= SP_RESET;
    else if (commit)
      sp <= sp + {{13{step[2]}}, step};
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: maps pipeline memory ops onto single-word accesses,
// splitting 32-bit stack transfers into two cycles and flagging bad addresses.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [15:0] SP_RESET = SP_RESET_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [2:0]  i_op,
  input  logic [15:0] i_address,
  input  logic [31:0] i_write_data,
  input  logic [15:0] i_mem_read_data,
  output logic [15:0] o_mem_address,
  output logic [15:0] o_mem_write_data,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [31:0] o_result,
  output logic        o_done,
  output logic        o_stall,
  output logic        o_mem_fault,
  output logic [15:0] o_sp
);

  state_t            state, state_nxt;
  mem_op_t           op, op_held;
  logic [15:0]       low_word;
  logic [15:0]       sp;
  logic signed [2:0] sp_step;
  logic              sp_commit;
  logic [15:0]       acc_addr, acc_data;
  logic              acc_rd, acc_wr, acc_done, acc_stall;
  logic              enter_second, fault, take_second;

  assign op          = mem_op_t'(i_op);
  assign o_sp        = sp;
  assign take_second = i_rst_n && enter_second && !fault;

  stack_pointer_unit #(.SP_RESET(SP_RESET)) u_sp (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .step   (sp_step),
    .commit (sp_commit),
    .sp     (sp)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      op_held  <= MEM_NONE;
      low_word <= 16'h0;
    end else begin
      state <= state_nxt;
      if (take_second) begin
        op_held <= op;
        if (acc_rd)
          low_word <= i_mem_read_data;
      end
    end
  end

  // Decode: the access this cycle would make if its address is legal.
  always_comb begin
    acc_addr     = 16'h0;
    acc_data     = 16'h0;
    acc_rd       = 1'b0;
    acc_wr       = 1'b0;
    acc_done     = 1'b0;
    acc_stall    = 1'b0;
    enter_second = 1'b0;
    sp_step      = 3'sd0;
    if (state == ST_SECOND) begin
      acc_done = 1'b1;
      if (op_held == MEM_PUSH32) begin
        acc_addr = sp - 16'd1;
        acc_data = i_write_data[15:0];
        acc_wr   = 1'b1;
        sp_step  = -3'sd2;
      end else begin
        acc_addr = sp + 16'd2;
        acc_rd   = 1'b1;
        sp_step  = 3'sd2;
      end
    end else if (i_valid) begin
      case (op)
        MEM_LOAD:   begin acc_addr = i_address; acc_rd = 1'b1; acc_done = 1'b1; end
        MEM_STORE:  begin
          acc_addr = i_address; acc_data = i_write_data[15:0];
          acc_wr = 1'b1; acc_done = 1'b1;
        end
        MEM_PUSH:   begin
          acc_addr = sp; acc_data = i_write_data[15:0];
          acc_wr = 1'b1; acc_done = 1'b1; sp_step = -3'sd1;
        end
        MEM_POP:    begin
          acc_addr = sp + 16'd1; acc_rd = 1'b1; acc_done = 1'b1; sp_step = 3'sd1;
        end
        MEM_PUSH32: begin
          acc_addr = sp; acc_data = i_write_data[31:16];
          acc_wr = 1'b1; acc_stall = 1'b1; enter_second = 1'b1;
        end
        MEM_POP32:  begin
          acc_addr = sp + 16'd1; acc_rd = 1'b1; acc_stall = 1'b1; enter_second = 1'b1;
        end
        default: ;
      endcase
    end
    fault = (acc_rd || acc_wr) && out_of_range(acc_addr, ADDR_W);
  end

  // Outputs and next state; a fault aborts the whole op with SP untouched.
  always_comb begin
    o_mem_address    = 16'h0;
    o_mem_write_data = 16'h0;
    o_mem_read       = 1'b0;
    o_mem_write      = 1'b0;
    o_result         = 32'h0;
    o_done           = 1'b0;
    o_stall          = 1'b0;
    o_mem_fault      = 1'b0;
    sp_commit        = 1'b0;
    state_nxt        = ST_IDLE;
    if (i_rst_n) begin
      if (fault) begin
        o_mem_fault = 1'b1;
        o_done      = 1'b1;
      end else begin
        o_mem_address    = acc_addr;
        o_mem_write_data = acc_data;
        o_mem_read       = acc_rd;
        o_mem_write      = acc_wr;
        o_done           = acc_done;
        o_stall          = acc_stall;
        sp_commit        = acc_done;
        state_nxt        = enter_second ? ST_SECOND : ST_IDLE;
        if (acc_rd && acc_done)
          o_result = (state == ST_SECOND) ? {i_mem_read_data, low_word}
                                          : {16'h0, i_mem_read_data};
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed ops push expected cycles,
// a negedge monitor pops and compares whenever the DUT reports done or stall.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [2:0]  op;
  logic [15:0] address;
  logic [31:0] write_data;
  logic [15:0] rd_data;
  logic [15:0] mem_address, mem_write_data;
  logic        mem_read, mem_write;
  logic [31:0] result;
  logic        done, stall, mem_fault;
  logic [15:0] sp;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rd;
    logic        wr;
    logic        done;
    logic        stall;
    logic        fault;
    logic [31:0] result;
    logic        chk_res;
    logic [15:0] sp;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [15:0] mem [0:4095];

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_valid          (valid),
    .i_op             (op),
    .i_address        (address),
    .i_write_data     (write_data),
    .i_mem_read_data  (rd_data),
    .o_mem_address    (mem_address),
    .o_mem_write_data (mem_write_data),
    .o_mem_read       (mem_read),
    .o_mem_write      (mem_write),
    .o_result         (result),
    .o_done           (done),
    .o_stall          (stall),
    .o_mem_fault      (mem_fault),
    .o_sp             (sp)
  );

  // Data memory model: writes commit on the falling edge, reads are combinational.
  assign rd_data = mem[mem_address[11:0]];
  always @(negedge clk) if (mem_write) mem[mem_address[11:0]] <= mem_write_data;
  initial for (int i = 0; i < 4096; i++) mem[i] = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && (done || stall)) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {30'h0, done, stall}, 32'h0);
      end else begin
        mon_e = q.pop_front();
        chk("mem_address", {16'h0, mem_address}, {16'h0, mon_e.addr});
        chk("mem_write_data", {16'h0, mem_write_data}, {16'h0, mon_e.wdata});
        chk("mem_read", {31'h0, mem_read}, {31'h0, mon_e.rd});
        chk("mem_write", {31'h0, mem_write}, {31'h0, mon_e.wr});
        chk("done", {31'h0, done}, {31'h0, mon_e.done});
        chk("stall", {31'h0, stall}, {31'h0, mon_e.stall});
        chk("mem_fault", {31'h0, mem_fault}, {31'h0, mon_e.fault});
        chk("sp", {16'h0, sp}, {16'h0, mon_e.sp});
        if (mon_e.chk_res) chk("result", result, mon_e.result);
      end
    end
  end

  task automatic exp_cyc(input logic [15:0] a, input logic [15:0] wd, input logic r, input logic w,
                         input logic d, input logic s, input logic f, input logic [31:0] res,
                         input logic cr, input logic [15:0] spv);
    exp_t e;
    e.addr = a; e.wdata = wd; e.rd = r; e.wr = w; e.done = d; e.stall = s;
    e.fault = f; e.result = res; e.chk_res = cr; e.sp = spv;
    q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [31:0] wd);
    valid = 1'b1; op = o; address = a; write_data = wd;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    valid = 1'b0; op = 3'd0; address = 16'h0; write_data = 32'h0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b1; op = 3'd1; address = 16'h0010; write_data = 32'h0;
    #12;
    chk("rst_read", {31'h0, mem_read}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_fault", {31'h0, mem_fault}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_address", {16'h0, mem_address}, 32'h0);
    chk("rst_sp", {16'h0, sp}, 32'h0FFF);
    valid = 1'b0; op = 3'd0;
    #1 rst_n = 1'b1;
    step();

    // PUSH then POP
    issue(3'd3, 16'h0, 32'h0000_ABCD);
    exp_cyc(16'h0FFF, 16'hABCD, 0, 1, 1, 0, 0, 32'h0, 0, 16'h0FFF);
    step();
    chk("sp_after_push", {16'h0, sp}, 32'h0FFE);
    issue(3'd4, 16'h0, 32'h0);
    exp_cyc(16'h0FFF, 16'h0, 1, 0, 1, 0, 0, 32'h0000_ABCD, 1, 16'h0FFE);
    step();
    chk("sp_after_pop", {16'h0, sp}, 32'h0FFF);

    // PUSH32 / POP32
    issue(3'd5, 16'h0, 32'h1234_5678);
    exp_cyc(16'h0FFF, 16'h1234, 0, 1, 0, 1, 0, 32'h0, 0, 16'h0FFF);
    step();
    exp_cyc(16'h0FFE, 16'h5678, 0, 1, 1, 0, 0, 32'h0, 0, 16'h0FFF);
    step();
    chk("sp_after_push32", {16'h0, sp}, 32'h0FFD);
    issue(3'd6, 16'h0, 32'h0);
    exp_cyc(16'h0FFE, 16'h0, 1, 0, 0, 1, 0, 32'h0, 0, 16'h0FFD);
    step();
    exp_cyc(16'h0FFF, 16'h0, 1, 0, 1, 0, 0, 32'h1234_5678, 1, 16'h0FFD);
    step();
    chk("sp_after_pop32", {16'h0, sp}, 32'h0FFF);

    // Out-of-range load, edge store, op 7 ignored
    issue(3'd1, 16'h1000, 32'h0);
    exp_cyc(16'h0, 16'h0, 0, 0, 1, 0, 1, 32'h0, 0, 16'h0FFF);
    step();
    issue(3'd2, 16'h0FFF, 32'h0000_BEEF);
    exp_cyc(16'h0FFF, 16'hBEEF, 0, 1, 1, 0, 0, 32'h0, 0, 16'h0FFF);
    step();
    issue(3'd1, 16'h0FFF, 32'h0);
    exp_cyc(16'h0FFF, 16'h0, 1, 0, 1, 0, 0, 32'h0000_BEEF, 1, 16'h0FFF);
    step();
    issue(3'd7, 16'h0FFF, 32'hFFFF_FFFF);
    #1;
    chk("op7_enables", {30'h0, mem_read, mem_write}, 32'h0);
    chk("op7_done", {31'h0, done}, 32'h0);
    step();

    // Back-to-back single-word ops
    issue(3'd2, 16'h0010, 32'h0000_1111);
    exp_cyc(16'h0010, 16'h1111, 0, 1, 1, 0, 0, 32'h0, 0, 16'h0FFF);
    step();
    issue(3'd1, 16'h0010, 32'h0);
    exp_cyc(16'h0010, 16'h0, 1, 0, 1, 0, 0, 32'h0000_1111, 1, 16'h0FFF);
    step();
    issue(3'd3, 16'h0, 32'h0000_2222);
    exp_cyc(16'h0FFF, 16'h2222, 0, 1, 1, 0, 0, 32'h0, 0, 16'h0FFF);
    step();
    issue(3'd4, 16'h0, 32'h0);
    exp_cyc(16'h0FFF, 16'h0, 1, 0, 1, 0, 0, 32'h0000_2222, 1, 16'h0FFE);
    step();

    // POP past the top faults; POP32 whose second half faults leaves SP intact
    issue(3'd4, 16'h0, 32'h0);
    exp_cyc(16'h0, 16'h0, 0, 0, 1, 0, 1, 32'h0, 0, 16'h0FFF);
    step();
    chk("sp_after_pop_fault", {16'h0, sp}, 32'h0FFF);
    issue(3'd3, 16'h0, 32'h0000_4444);
    exp_cyc(16'h0FFF, 16'h4444, 0, 1, 1, 0, 0, 32'h0, 0, 16'h0FFF);
    step();
    issue(3'd6, 16'h0, 32'h0);
    exp_cyc(16'h0FFF, 16'h0, 1, 0, 0, 1, 0, 32'h0, 0, 16'h0FFE);
    step();
    exp_cyc(16'h0, 16'h0, 0, 0, 1, 0, 1, 32'h0, 0, 16'h0FFE);
    step();
    chk("sp_after_pop32_fault", {16'h0, sp}, 32'h0FFE);
    issue(3'd4, 16'h0, 32'h0);
    exp_cyc(16'h0FFF, 16'h0, 1, 0, 1, 0, 0, 32'h0000_4444, 1, 16'h0FFE);
    step();

    // Reset in the second cycle of PUSH32
    issue(3'd5, 16'h0, 32'hAAAA_5555);
    exp_cyc(16'h0FFF, 16'hAAAA, 0, 1, 0, 1, 0, 32'h0, 0, 16'h0FFF);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_write", {31'h0, mem_write}, 32'h0);
    chk("midrst_done_stall", {30'h0, done, stall}, 32'h0);
    chk("midrst_sp", {16'h0, sp}, 32'h0FFF);
    chk("midrst_result", result, 32'h0);
    @(negedge clk); #1;
    valid = 1'b0; op = 3'd0;
    rst_n = 1'b1;
    step();
    chk("midrst_no_second_write", {16'h0, mem[4094]}, 32'h5678);
    chk("midrst_first_write", {16'h0, mem[4095]}, 32'hAAAA);
    issue(3'd3, 16'h0, 32'h0000_7777);
    exp_cyc(16'h0FFF, 16'h7777, 0, 1, 1, 0, 0, 32'h0, 0, 16'h0FFF);
    step();
    issue(3'd4, 16'h0, 32'h0);
    exp_cyc(16'h0FFF, 16'h0, 1, 0, 1, 0, 0, 32'h0000_7777, 1, 16'h0FFE);
    step();
    idle();
    idle();
    chk("queue_drained", q.size(), 32'h0);
    chk("final_sp", {16'h0, sp}, 32'h0FFF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage sequencer that sits directly upstream of the 16-bit data memory (4K words, read/write committed on the falling clock edge).
- Turns pipeline memory operations (load, store, push, pop, and 32-bit push/pop for CALL/RET/INT/RTI) into single-word memory accesses.
- Owns the stack pointer, splits 32-bit stack transfers into two consecutive word accesses, and stalls the pipeline for the extra cycle.
- Flags out-of-range addresses and suppresses the access.

Parameters:
- ADDR_W, 12: implemented memory address bits; the legal range is 0 to 2**ADDR_W-1.
- SP_RESET, 16'h0FFF: stack pointer value after reset. The stack grows downward.

Ports:
- i_clk  in  1  pipeline clock; SP and FSM update on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  an operation is present in the EX/MEM register.
- i_op  in  3  0=NONE 1=LOAD 2=STORE 3=PUSH 4=POP 5=PUSH32 6=POP32; 7 is treated as NONE.
- i_address  in  16  effective address for LOAD/STORE.
- i_write_data  in  32  store/push data; only [15:0] is used by single-word operations.
- i_mem_read_data  in  16  read data from the data memory.
- o_mem_address  out  16  address to the data memory.
- o_mem_write_data  out  16  write data to the data memory.
- o_mem_read  out  1  memory read enable.
- o_mem_write  out  1  memory write enable.
- o_result  out  32  load/pop result: {16'h0, word} or {high, low}.
- o_done  out  1  the operation completes this cycle.
- o_stall  out  1  hold the upstream pipeline this cycle.
- o_mem_fault  out  1  out-of-range access; asserted for one cycle.
- o_sp  out  16  current stack pointer.

Behaviour:
- Reset (async, i_rst_n=0):
  - FSM goes to IDLE; SP=SP_RESET; low-half register=0.
  - All memory enables, o_done, o_stall and o_mem_fault are 0; o_result=0.
  - Reset during the SECOND state abandons the operation. No second access is issued.
- All outputs are combinational from state, SP and inputs. Memory read data is valid after the falling edge and is sampled at the next rising edge.
- IDLE, with i_valid=1:
  - LOAD: addr=i_address, read=1, done=1, result={16'h0, i_mem_read_data}.
  - STORE: addr=i_address, write=1, data=i_write_data[15:0], done=1.
  - PUSH: addr=SP, write=1, data=i_write_data[15:0], done=1; SP<=SP-1.
  - POP: addr=SP+1, read=1, done=1, result={16'h0, read data}; SP<=SP+1.
  - PUSH32: addr=SP, write=1, data=i_write_data[31:16], stall=1; go to SECOND.
  - POP32: addr=SP+1, read=1, stall=1; capture read data into the low register; go to SECOND.
- IDLE with i_valid=0 or op NONE: no enables, done=0, SP unchanged.
- SECOND, PUSH32: addr=SP-1, write=1, data=i_write_data[15:0], done=1, stall=0; SP<=SP-2; go to IDLE.
  - Memory layout: high half at the higher address, low half at the lower address.
- SECOND, POP32: addr=SP+2, read=1, done=1, result={i_mem_read_data, low_reg}; SP<=SP+2; go to IDLE.
- In SECOND, i_op and i_write_data are held stable by upstream because o_stall was high the previous cycle. The controller uses the latched op type, not i_op.
- SP arithmetic is 16-bit modulo 2**16. Wrap is legal for SP, but any resulting address at or above 2**ADDR_W faults.
- Fault: when the computed address is at or above 2**ADDR_W:
  - o_mem_fault=1, read=write=0, done=1.
  - The operation is aborted. SP is unchanged, including any partial 32-bit update, and the FSM returns to IDLE.
  - If the first half of a PUSH32 faults, no stall is raised.
- o_mem_address and o_mem_write_data are 0 whenever both enables are 0.
- Throughput: one single-word op per cycle; a 32-bit op occupies 2 cycles.

Decomposition:
- Shared package mem_pkg holds:
  - op encodings MEM_NONE..MEM_POP32;
  - FSM state encodings ST_IDLE/ST_SECOND;
  - the default SP_RESET and ADDR_W constants.
- One natural sub-module, stack_pointer_unit: SP register with async reset, a step input (-2, -1, 0, +1, +2) and a commit enable.

Test Plan:
- Reset, then PUSH 16'hABCD -> write to addr 16'h0FFF with data ABCD, done=1, o_sp=16'h0FFE. Then POP -> read at 16'h0FFF, o_result=16'h0000ABCD, o_sp=16'h0FFF.
- PUSH32 32'h1234_5678 from SP=0FFF:
  - cycle 1: stall=1, write 1234 at 0FFF;
  - cycle 2: write 5678 at 0FFE, done=1;
  - SP=0FFD.
- POP32 from SP=0FFD -> reads at 0FFE then 0FFF; o_result=32'h1234_5678 on cycle 2; SP=0FFF; stall only in cycle 1.
- LOAD at 16'h1000 (ADDR_W=12) -> o_mem_fault=1, no enables, done=1, SP unchanged. STORE at 16'h0FFF -> succeeds.
- Assert i_rst_n=0 in the SECOND cycle of a PUSH32 -> no second write, SP=0FFF, outputs 0. The next op after release executes normally.
- Back-to-back STORE, LOAD, PUSH, POP at one op per cycle -> no stalls, each done=1, correct addresses and data every cycle.
